// File: rtl/rgb_fade_sequencer.sv
// Colour-fade sequencer for the RGB PWM driver: fades linearly between four palette
// colours, holds each one for a fixed number of step ticks, then moves to the next.
module rgb_fade_sequencer #(
    parameter int STEP_DIV   = 50000,
    parameter int HOLD_STEPS = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        cfg_we,
    input  logic [1:0]  cfg_addr,
    input  logic [23:0] cfg_rgb,
    output logic [7:0]  r_duty,
    output logic [7:0]  g_duty,
    output logic [7:0]  b_duty,
    output logic [1:0]  color_idx,
    output logic        busy,
    output logic        seq_wrap
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FADE = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam int CNT_W  = (STEP_DIV > 1)   ? $clog2(STEP_DIV)   : 1;
    localparam int HOLD_W = (HOLD_STEPS > 1) ? $clog2(HOLD_STEPS) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(STEP_DIV - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_STEPS - 1);

    // One-unit move toward the target; can never leave 0..255.
    function automatic logic [7:0] step_toward(input logic [7:0] cur, input logic [7:0] tgt);
        if (cur < tgt) begin
            return cur + 8'd1;
        end else if (cur > tgt) begin
            return cur - 8'd1;
        end else begin
            return cur;
        end
    endfunction

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [7:0]          r_q, r_d, g_q, g_d, b_q, b_d;
    logic [1:0]          idx_q, idx_d;
    logic                busy_q, busy_d;
    logic                wrap_q, wrap_d;
    logic [23:0]         palette_q [4];
    logic [23:0]         palette_d [4];

    logic                tick;
    logic [23:0]         tgt;
    logic [7:0]          r_step, g_step, b_step;

    always_comb begin
        tgt    = palette_q[idx_q];
        tick   = (state_q != IDLE) && (cnt_q == CNT_LAST);
        r_step = step_toward(r_q, tgt[23:16]);
        g_step = step_toward(g_q, tgt[15:8]);
        b_step = step_toward(b_q, tgt[7:0]);

        state_d = state_q;
        hold_d  = hold_q;
        r_d     = r_q;
        g_d     = g_q;
        b_d     = b_q;
        idx_d   = idx_q;
        wrap_d  = 1'b0;

        // Tick phase restarts from zero every time the sequence leaves IDLE.
        if (state_q == IDLE || !enable || tick) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                hold_d = '0;
                if (enable) begin
                    state_d = FADE;
                end
            end
            FADE: begin
                if (!enable) begin
                    state_d = IDLE;
                    hold_d  = '0;
                end else if (tick) begin
                    r_d = r_step;
                    g_d = g_step;
                    b_d = b_step;
                    if ({r_step, g_step, b_step} == tgt) begin
                        state_d = HOLD;
                        hold_d  = '0;
                    end
                end
            end
            HOLD: begin
                if (!enable) begin
                    state_d = IDLE;
                    hold_d  = '0;
                end else if (tick) begin
                    if (hold_q == HOLD_LAST) begin
                        hold_d  = '0;
                        idx_d   = idx_q + 2'd1;
                        wrap_d  = (idx_q == 2'd3);
                        state_d = FADE;
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                hold_d  = '0;
            end
        endcase

        busy_d = (state_d != IDLE);

        for (int i = 0; i < 4; i++) begin
            palette_d[i] = palette_q[i];
        end
        if (cfg_we) begin
            palette_d[cfg_addr] = cfg_rgb;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hold_q  <= '0;
            r_q     <= 8'd0;
            g_q     <= 8'd0;
            b_q     <= 8'd0;
            idx_q   <= 2'd0;
            busy_q  <= 1'b0;
            wrap_q  <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                palette_q[i] <= 24'd0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
            r_q     <= r_d;
            g_q     <= g_d;
            b_q     <= b_d;
            idx_q   <= idx_d;
            busy_q  <= busy_d;
            wrap_q  <= wrap_d;
            for (int i = 0; i < 4; i++) begin
                palette_q[i] <= palette_d[i];
            end
        end
    end

    assign r_duty    = r_q;
    assign g_duty    = g_q;
    assign b_duty    = b_q;
    assign color_idx = idx_q;
    assign busy      = busy_q;
    assign seq_wrap  = wrap_q;

endmodule

// File: tb/tb_rgb_fade_sequencer.sv
// Bench for rgb_fade_sequencer: directed scenarios plus random stimulus, with a
// behavioural model feeding an expected-output queue that a monitor drains each cycle.
module tb_rgb_fade_sequencer;

    localparam int SD = 4;
    localparam int HS = 2;

    logic        clk;
    logic        rst;
    logic        enable;
    logic        cfg_we;
    logic [1:0]  cfg_addr;
    logic [23:0] cfg_rgb;
    logic [7:0]  r_duty, g_duty, b_duty;
    logic [1:0]  color_idx;
    logic        busy;
    logic        seq_wrap;

    rgb_fade_sequencer #(.STEP_DIV(SD), .HOLD_STEPS(HS)) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_rgb   (cfg_rgb),
        .r_duty    (r_duty),
        .g_duty    (g_duty),
        .b_duty    (b_duty),
        .color_idx (color_idx),
        .busy      (busy),
        .seq_wrap  (seq_wrap)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int n_tests = 0;
    int n_fail  = 0;
    int wrap_seen = 0;

    logic [27:0] sb_q [$];

    // Reference model: channel values as plain integers, tick timing from elapsed active cycles.
    logic [23:0] m_pal [4];
    int m_r, m_g, m_b, m_idx;
    bit m_active, m_holding, m_wrap;
    int m_hold, m_start, m_cyc;

    function automatic int sgn(input int v);
        return (v > 0) ? 1 : ((v < 0) ? -1 : 0);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_pal[i] = 24'd0;
        m_r = 0; m_g = 0; m_b = 0; m_idx = 0;
        m_active = 0; m_holding = 0; m_wrap = 0;
        m_hold = 0; m_start = 0; m_cyc = 0;
    endtask

    task automatic model_step(input bit en, input bit we, input logic [1:0] addr, input logic [23:0] rgb);
        logic [23:0] t;
        int tr, tg, tb;
        bit tk;
        t  = m_pal[m_idx];
        tr = int'(t[23:16]);
        tg = int'(t[15:8]);
        tb = int'(t[7:0]);
        tk = m_active && (((m_cyc - m_start) % SD) == SD - 1);
        m_wrap = 0;
        if (!m_active) begin
            if (en) begin
                m_active = 1; m_holding = 0; m_hold = 0; m_start = m_cyc + 1;
            end
        end else if (!en) begin
            m_active = 0; m_holding = 0; m_hold = 0;
        end else if (tk) begin
            if (!m_holding) begin
                m_r += sgn(tr - m_r);
                m_g += sgn(tg - m_g);
                m_b += sgn(tb - m_b);
                if (m_r == tr && m_g == tg && m_b == tb) begin
                    m_holding = 1; m_hold = 0;
                end
            end else begin
                m_hold++;
                if (m_hold == HS) begin
                    m_wrap = (m_idx == 3);
                    m_idx = (m_idx + 1) % 4;
                    m_holding = 0; m_hold = 0;
                end
            end
        end
        if (we) m_pal[addr] = rgb;
        m_cyc++;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs and queue what the outputs must be after the next edge.
    task automatic cycle(input bit en, input bit we = 0, input logic [1:0] addr = 2'd0,
                         input logic [23:0] rgb = 24'd0);
        @(negedge clk);
        enable   = en;
        cfg_we   = we;
        cfg_addr = addr;
        cfg_rgb  = rgb;
        model_step(en, we, addr, rgb);
        sb_q.push_back({8'(m_r), 8'(m_g), 8'(m_b), 2'(m_idx), m_active, m_wrap});
    endtask

    // Call shortly after a rising edge; asserts reset between edges.
    task automatic async_reset();
        #1;
        enable = 1'b0;
        cfg_we = 1'b0;
        rst    = 1'b1;
        #1;
        check("async_rst_outputs", int'({r_duty, g_duty, b_duty, color_idx, busy, seq_wrap}), 0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic monitor();
        logic [27:0] exp, got;
        forever begin
            @(posedge clk);
            #1;
            if (seq_wrap) wrap_seen++;
            if (sb_q.size() > 0) begin
                exp = sb_q.pop_front();
                got = {r_duty, g_duty, b_duty, color_idx, busy, seq_wrap};
                n_tests++;
                if (got !== exp) begin
                    n_fail++;
                    $display("FAIL scoreboard @%0t: got r=%0d g=%0d b=%0d idx=%0d busy=%0d wrap=%0d expected r=%0d g=%0d b=%0d idx=%0d busy=%0d wrap=%0d",
                             $time, got[27:20], got[19:12], got[11:4], got[3:2], got[1], got[0],
                             exp[27:20], exp[19:12], exp[11:4], exp[3:2], exp[1], exp[0]);
                end
            end
        end
    endtask

    initial begin
        int w0;
        logic [1:0] a;
        logic [23:0] v;
        rst = 1'b1; enable = 1'b0; cfg_we = 1'b0; cfg_addr = 2'd0; cfg_rgb = 24'd0;
        model_reset();
        fork
            monitor();
        join_none
        repeat (2) @(negedge clk);
        check("reset_outputs", int'({r_duty, g_duty, b_duty, color_idx, busy, seq_wrap}), 0);
        rst = 1'b0;

        // Idle with a palette write: nothing may move.
        cycle(0, 1, 2'd0, 24'h030100);
        repeat (19) cycle(0);
        check("idle_wraps", wrap_seen, 0);

        // Fade up to {3,1,0}.
        repeat (13) cycle(1);
        @(posedge clk); #2;
        check("fadeup_r_tick3", int'(r_duty), 3);
        check("fadeup_g_tick3", int'(g_duty), 1);
        repeat (8) cycle(1);
        @(posedge clk); #2;
        check("hold_advance_idx", int'(color_idx), 1);

        // Fade down to palette[1] = 0.
        repeat (12) cycle(1);
        @(posedge clk); #2;
        check("fadedown_r_zero", int'(r_duty), 0);
        check("fadedown_g_zero", int'(g_duty), 0);
        repeat (20) cycle(1);

        // Full palette cycle with exactly one wrap.
        @(posedge clk); #2;
        async_reset();
        cycle(0, 1, 2'd0, 24'h0A0000);
        cycle(0, 1, 2'd1, 24'h000A00);
        cycle(0, 1, 2'd2, 24'h00000A);
        cycle(0, 1, 2'd3, 24'h000000);
        w0 = wrap_seen;
        repeat (250) cycle(1);
        @(posedge clk); #2;
        check("full_cycle_wraps", wrap_seen - w0, 1);

        // Pause mid-fade, retarget the current entry, resume.
        cycle(0);
        @(posedge clk); #2;
        check("pause_busy", int'(busy), 0);
        repeat (5) cycle(0);
        cycle(0, 1, 2'(m_idx), 24'hFF0000);
        repeat (1100) cycle(1);

        // Reset while holding at r=10.
        @(posedge clk); #2;
        async_reset();
        cycle(0, 1, 2'd0, 24'h0A0000);
        repeat (42) cycle(1);
        @(posedge clk); #2;
        check("hold_r_before_reset", int'(r_duty), 10);
        check("hold_busy_before_reset", int'(busy), 1);
        async_reset();
        repeat (30) cycle(1);
        @(posedge clk); #2;
        check("post_reset_no_fade", int'(r_duty), 0);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            a = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 19) == 0)
                v = 24'($urandom());
            else
                v = {8'($urandom_range(0, 12)), 8'($urandom_range(0, 12)), 8'($urandom_range(0, 12))};
            cycle($urandom_range(0, 99) >= 3, $urandom_range(0, 99) < 3, a, v);
        end

        repeat (2) @(posedge clk);
        #3;
        check("scoreboard_drained", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
